// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared ALU arbiter: two requesters, each
// with an operation handshake and a single-entry result slot.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_in1;
    logic [31:0] req0_in2;
    logic [3:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_in1;
    logic [31:0] req1_in2;
    logic [3:0]  req1_op;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        rsp1_ready;
    logic        grant_id;

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_op,
        output req1_valid, req1_in1, req1_in2, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, grant_id
    );

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_op,
        input  req1_valid, req1_in1, req1_in2, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, grant_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shared 32-bit ALU with a two-requester arbiter. Requester 0 is the integer
// execute path, requester 1 the branch-compare path. The winning request
// drives the ALU combinationally; the result lands in that requester's
// single-entry result register one cycle after acceptance.

// 32-bit ALU. Opcode {alt, funct3}: arithmetic/logic in 0000-1000 plus 1101
// (sra); the remaining 1xxx codes are branch compares returning 0/1 in bit 0.
// Shift amounts come from in2[3:0] only.
module alu_32_bit (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  op,
    output logic [31:0] out
);
    logic [3:0] shamt;

    assign shamt = in2[3:0];

    // Opcode decode
    always_comb begin
        out = '0;
        case (op)
            4'b0000: out = in1 + in2;
            4'b0001: out = in1 << shamt;
            4'b0010: out = {31'b0, $signed(in1) < $signed(in2)};
            4'b0011: out = {31'b0, in1 < in2};
            4'b0100: out = in1 ^ in2;
            4'b0101: out = in1 >> shamt;
            4'b0110: out = in1 | in2;
            4'b0111: out = in1 & in2;
            4'b1000: out = in1 - in2;
            4'b1001: out = {31'b0, in1 == in2};
            4'b1010: out = {31'b0, in1 != in2};
            4'b1011: out = {31'b0, $signed(in1) < $signed(in2)};
            4'b1100: out = {31'b0, $signed(in1) >= $signed(in2)};
            4'b1101: out = $unsigned($signed(in1) >>> shamt);
            4'b1110: out = {31'b0, in1 < in2};
            4'b1111: out = {31'b0, in1 >= in2};
            default: out = '0;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    logic        ptr;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp0_data_q;
    logic [31:0] rsp1_data_q;
    logic        grant_id_q;
    logic        slot0_free;
    logic        slot1_free;
    logic        elig0;
    logic        elig1;
    logic        grant0;
    logic        grant1;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;

    // A full slot being drained this cycle can take a new result; nothing is
    // accepted while reset is held.
    assign slot0_free = !rsp0_valid_q || bus.rsp0_ready;
    assign slot1_free = !rsp1_valid_q || bus.rsp1_ready;
    assign elig0      = !rst && bus.req0_valid && slot0_free;
    assign elig1      = !rst && bus.req1_valid && slot1_free;

    // Grant selection: pointer breaks ties in round-robin mode, requester 0
    // wins ties otherwise.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (RR_EN && ptr) grant1 = 1'b1;
            else              grant0 = 1'b1;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    // Operand mux: requester 0 is the idle default, its result is then unused.
    always_comb begin
        alu_in1 = bus.req0_in1;
        alu_in2 = bus.req0_in2;
        alu_op  = bus.req0_op;
        if (grant1) begin
            alu_in1 = bus.req1_in1;
            alu_in2 = bus.req1_in2;
            alu_op  = bus.req1_op;
        end
    end

    alu_32_bit u_alu (
        .in1 (alu_in1),
        .in2 (alu_in2),
        .op  (alu_op),
        .out (alu_out)
    );

    // Result capture, drain, last-grant tracking and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            grant_id_q   <= 1'b0;
            ptr          <= 1'b0;
        end else begin
            if (grant0) begin
                rsp0_data_q  <= alu_out;
                rsp0_valid_q <= 1'b1;
            end else if (rsp0_valid_q && bus.rsp0_ready) begin
                rsp0_valid_q <= 1'b0;
            end
            if (grant1) begin
                rsp1_data_q  <= alu_out;
                rsp1_valid_q <= 1'b1;
            end else if (rsp1_valid_q && bus.rsp1_ready) begin
                rsp1_valid_q <= 1'b0;
            end
            if (grant0 || grant1) begin
                grant_id_q <= grant1;
                if (RR_EN) ptr <= grant0;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.grant_id   = grant_id_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_alu_share_arbiter;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    alu_share_arbiter_if bus_rr ();
    alu_share_arbiter_if bus_fp ();

    alu_share_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    alu_share_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_rr.req0_valid = 0; bus_rr.req0_in1 = 0; bus_rr.req0_in2 = 0; bus_rr.req0_op = 0;
        bus_rr.req1_valid = 0; bus_rr.req1_in1 = 0; bus_rr.req1_in2 = 0; bus_rr.req1_op = 0;
        bus_rr.rsp0_ready = 0; bus_rr.rsp1_ready = 0;
        bus_fp.req0_valid = 0; bus_fp.req0_in1 = 0; bus_fp.req0_in2 = 0; bus_fp.req0_op = 0;
        bus_fp.req1_valid = 0; bus_fp.req1_in1 = 0; bus_fp.req1_in2 = 0; bus_fp.req1_op = 0;
        bus_fp.rsp0_ready = 0; bus_fp.rsp1_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0 || bus_rr.grant_id !== 1'b0)
            $display("FAIL reset_init: v0=%b v1=%b gid=%b, want 0 0 0",
                     bus_rr.rsp0_valid, bus_rr.rsp1_valid, bus_rr.grant_id);
        else pass_cnt++;
        // fill both slots: req0 then req1, leaving grant_id=1
        bus_rr.req0_valid = 1; bus_rr.req0_in1 = 5; bus_rr.req0_in2 = 7; bus_rr.req0_op = 4'b0000;
        step();
        bus_rr.req0_valid = 0;
        bus_rr.req1_valid = 1; bus_rr.req1_in1 = 2; bus_rr.req1_in2 = 3; bus_rr.req1_op = 4'b0000;
        step();
        bus_rr.req1_valid = 0;
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp1_data !== 32'd5 || bus_rr.grant_id !== 1'b1)
            $display("FAIL reset_prefill: v0=%b d1=%0d gid=%b, want 1 5 1",
                     bus_rr.rsp0_valid, bus_rr.rsp1_data, bus_rr.grant_id);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0 ||
            bus_rr.rsp0_data !== 32'd0 || bus_rr.rsp1_data !== 32'd0 || bus_rr.grant_id !== 1'b0)
            $display("FAIL reset_async: v0=%b v1=%b d0=%0d d1=%0d gid=%b, want all 0",
                     bus_rr.rsp0_valid, bus_rr.rsp1_valid, bus_rr.rsp0_data,
                     bus_rr.rsp1_data, bus_rr.grant_id);
        else pass_cnt++;
        bus_rr.req0_valid = 1; bus_rr.req1_valid = 1;
        bus_rr.rsp0_ready = 1; bus_rr.rsp1_ready = 1;
        #1;
        total_cnt++;
        if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b0)
            $display("FAIL reset_no_accept: rdy0=%b rdy1=%b, want 0 0",
                     bus_rr.req0_ready, bus_rr.req1_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0)
            $display("FAIL reset_hold: v0=%b v1=%b, want 0 0", bus_rr.rsp0_valid, bus_rr.rsp1_valid);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0)
            $display("FAIL reset_first_grant: rdy0=%b rdy1=%b, want 1 0",
                     bus_rr.req0_ready, bus_rr.req1_ready);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_single_add();
        do_reset();
        bus_rr.req0_valid = 1; bus_rr.req0_in1 = 5; bus_rr.req0_in2 = 7; bus_rr.req0_op = 4'b0000;
        #1;
        total_cnt++;
        if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0)
            $display("FAIL add_ready: rdy0=%b rdy1=%b, want 1 0", bus_rr.req0_ready, bus_rr.req1_ready);
        else pass_cnt++;
        step();
        bus_rr.req0_valid = 0;
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_data !== 32'd12 || bus_rr.rsp1_valid !== 1'b0)
            $display("FAIL add_result: v0=%b d0=%0d v1=%b, want 1 12 0",
                     bus_rr.rsp0_valid, bus_rr.rsp0_data, bus_rr.rsp1_valid);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_contention_rr();
        do_reset();
        bus_rr.req0_valid = 1; bus_rr.req0_in1 = 10; bus_rr.req0_in2 = 3; bus_rr.req0_op = 4'b1000;
        bus_rr.req1_valid = 1; bus_rr.req1_in1 = 32'hFFFF_FFFF; bus_rr.req1_in2 = 1; bus_rr.req1_op = 4'b1011;
        bus_rr.rsp0_ready = 1; bus_rr.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            #1;
            total_cnt++;
            if (bus_rr.req0_ready !== !g || bus_rr.req1_ready !== g)
                $display("FAIL rr_ready[%0d]: rdy0=%b rdy1=%b, want %b %b",
                         i, bus_rr.req0_ready, bus_rr.req1_ready, !g, g);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus_rr.grant_id !== g ||
                (!g && bus_rr.rsp0_data !== 32'd7) || (g && bus_rr.rsp1_data !== 32'd1))
                $display("FAIL rr_result[%0d]: gid=%b d0=%0d d1=%0d, want gid=%b (d0=7 or d1=1)",
                         i, bus_rr.grant_id, bus_rr.rsp0_data, bus_rr.rsp1_data, g);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_contention_fixed();
        do_reset();
        bus_fp.req0_valid = 1; bus_fp.req0_in1 = 10; bus_fp.req0_in2 = 3; bus_fp.req0_op = 4'b1000;
        bus_fp.req1_valid = 1; bus_fp.req1_in1 = 32'hFFFF_FFFF; bus_fp.req1_in2 = 1; bus_fp.req1_op = 4'b1011;
        bus_fp.rsp0_ready = 1; bus_fp.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (bus_fp.req0_ready !== 1'b1 || bus_fp.req1_ready !== 1'b0)
                $display("FAIL fp_ready[%0d]: rdy0=%b rdy1=%b, want 1 0",
                         i, bus_fp.req0_ready, bus_fp.req1_ready);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus_fp.grant_id !== 1'b0 || bus_fp.rsp0_data !== 32'd7 || bus_fp.rsp1_valid !== 1'b0)
                $display("FAIL fp_result[%0d]: gid=%b d0=%0d v1=%b, want 0 7 0",
                         i, bus_fp.grant_id, bus_fp.rsp0_data, bus_fp.rsp1_valid);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_rr.req0_valid = 1; bus_rr.req0_in1 = 1; bus_rr.req0_in2 = 2; bus_rr.req0_op = 4'b0000;
        step();
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_data !== 32'd3)
            $display("FAIL bp_fill: v0=%b d0=%0d, want 1 3", bus_rr.rsp0_valid, bus_rr.rsp0_data);
        else pass_cnt++;
        bus_rr.req0_in1 = 10; bus_rr.req0_in2 = 20;
        bus_rr.req1_valid = 1; bus_rr.req1_in1 = 4; bus_rr.req1_in2 = 4; bus_rr.req1_op = 4'b1001;
        bus_rr.rsp1_ready = 1;
        #1;
        total_cnt++;
        if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b1)
            $display("FAIL bp_ready: rdy0=%b rdy1=%b, want 0 1", bus_rr.req0_ready, bus_rr.req1_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_data !== 32'd3 ||
            bus_rr.rsp1_data !== 32'd1 || bus_rr.grant_id !== 1'b1)
            $display("FAIL bp_hold: v0=%b d0=%0d d1=%0d gid=%b, want 1 3 1 1",
                     bus_rr.rsp0_valid, bus_rr.rsp0_data, bus_rr.rsp1_data, bus_rr.grant_id);
        else pass_cnt++;
        bus_rr.req1_valid = 0;
        bus_rr.rsp0_ready = 1;
        #1;
        total_cnt++;
        if (bus_rr.req0_ready !== 1'b1)
            $display("FAIL bp_release_ready: rdy0=%b, want 1", bus_rr.req0_ready);
        else pass_cnt++;
        step();
        bus_rr.req0_valid = 0;
        bus_rr.rsp0_ready = 0;
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_data !== 32'd30)
            $display("FAIL bp_refill: v0=%b d0=%0d, want 1 30", bus_rr.rsp0_valid, bus_rr.rsp0_data);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_vec [3];
        logic [31:0] b_vec [3];
        logic [31:0] r_vec [3];
        a_vec[0] = 3; b_vec[0] = 5; r_vec[0] = 0;
        a_vec[1] = 5; b_vec[1] = 3; r_vec[1] = 1;
        a_vec[2] = 7; b_vec[2] = 7; r_vec[2] = 1;
        do_reset();
        bus_rr.rsp1_ready = 1;
        bus_rr.req1_valid = 1; bus_rr.req1_op = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            bus_rr.req1_in1 = a_vec[i];
            bus_rr.req1_in2 = b_vec[i];
            #1;
            total_cnt++;
            if (bus_rr.req1_ready !== 1'b1)
                $display("FAIL b2b_ready[%0d]: rdy1=%b, want 1", i, bus_rr.req1_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp1_data !== r_vec[i])
                $display("FAIL b2b_result[%0d]: v1=%b d1=%0d, want 1 %0d",
                         i, bus_rr.rsp1_valid, bus_rr.rsp1_data, r_vec[i]);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_drain();
        do_reset();
        bus_rr.req0_valid = 1; bus_rr.req0_in1 = 9; bus_rr.req0_in2 = 4; bus_rr.req0_op = 4'b1000;
        step();
        bus_rr.req0_valid = 0;
        bus_rr.rsp0_ready = 1;
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_data !== 32'd5)
            $display("FAIL drain_fill: v0=%b d0=%0d, want 1 5", bus_rr.rsp0_valid, bus_rr.rsp0_data);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp0_data !== 32'd5)
            $display("FAIL drain_empty: v0=%b d0=%0d, want 0 5", bus_rr.rsp0_valid, bus_rr.rsp0_data);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        idle();
        #12;
        test_reset();
        test_single_add();
        test_contention_rr();
        test_contention_fixed();
        test_backpressure();
        test_back_to_back();
        test_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
